// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl: SCC68070 system-bus glue. Decodes NUM_REGIONS address
// windows into registered one-hot chip selects, inserts per-region wait
// states or waits for an external slave acknowledge, and answers unmapped
// or timed-out accesses with a bus error while keeping error statistics.
module attex_bus_ctrl #(
    parameter int                          NUM_REGIONS   = 5,
    parameter int                          DATA_W        = 16,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_BASE   = '0,
    parameter logic [NUM_REGIONS*24-1:0]   REGION_MASK   = '0,
    parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT   = '0,
    parameter logic [NUM_REGIONS-1:0]      REGION_EXTACK = '0,
    parameter int                          TIMEOUT       = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          as,
    input  logic                          uds,
    input  logic                          lds,
    input  logic                          write_strobe,
    input  logic [23:1]                   addr,
    input  logic [NUM_REGIONS*DATA_W-1:0] region_dout,
    input  logic [NUM_REGIONS-1:0]        region_ack,
    output logic [NUM_REGIONS-1:0]        cs,
    output logic [DATA_W-1:0]             data_in,
    output logic                          bus_ack,
    output logic                          bus_err,
    output logic [7:0]                    err_count,
    output logic [23:0]                   last_err_addr
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD,
        S_ERR
    } state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [3:0]             wait_cnt, wait_nx;
    logic [15:0]            to_cnt, to_nx, to_inc;
    logic [NUM_REGIONS-1:0] cs_nx;

    logic                   req;
    logic [23:0]            addr_byte;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_idx;
    logic [3:0]             hit_wait;
    logic                   hit_ext;
    logic                   sel_ext;
    logic                   sel_ack;
    logic                   wait_done;

    // write_strobe does not take part in decode; reads and writes are identical
    logic                   unused_write_strobe;
    assign unused_write_strobe = write_strobe;

    assign req       = as && (uds || lds);
    assign addr_byte = {addr, 1'b0};
    assign sel_ext   = REGION_EXTACK[idx];
    assign sel_ack   = region_ack[idx];
    assign to_inc    = to_cnt + 16'd1;

    // Address decode: lowest-index enabled region that matches wins
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (!hit_any && (REGION_MASK[i*24 +: 24] != 24'd0) &&
                ((addr_byte & REGION_MASK[i*24 +: 24]) ==
                 (REGION_BASE[i*24 +: 24] & REGION_MASK[i*24 +: 24]))) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_wait = REGION_WAIT[hit_idx*4 +: 4];
        hit_ext  = REGION_EXTACK[hit_idx];
    end

    // Next-state logic; internal regions with zero wait states acknowledge
    // straight from IDLE, and internal waits leave WAIT as the count reaches
    // zero, so the ack lands WAIT cycles after the chip select rises.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        wait_nx   = wait_cnt;
        to_nx     = to_cnt;
        wait_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        idx_nx   = hit_idx;
                        wait_nx  = hit_wait;
                        to_nx    = '0;
                        state_nx = (!hit_ext && (hit_wait == 4'd0)) ? S_ACK : S_WAIT;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (!as) begin
                    state_nx = S_IDLE;
                end else begin
                    to_nx = to_inc;
                    if (wait_cnt != 4'd0) begin
                        wait_nx = wait_cnt - 4'd1;
                    end
                    wait_done = sel_ext ? ((wait_cnt == 4'd0) && sel_ack)
                                        : (wait_cnt <= 4'd1);
                    if (wait_done) begin
                        state_nx = S_ACK;
                    end else if (to_inc == 16'(TIMEOUT)) begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_ACK:  state_nx = S_HOLD;
            S_HOLD: if (!as) state_nx = S_IDLE;
            S_ERR:  if (!as) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Chip select for the state being entered, so cs is a plain flop
    always_comb begin
        cs_nx = '0;
        if ((state_nx == S_WAIT) || (state_nx == S_ACK) || (state_nx == S_HOLD)) begin
            cs_nx = NUM_REGIONS'(1) << idx_nx;
        end
    end

    // State, counters, registered outputs and error statistics
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            to_cnt        <= '0;
            cs            <= '0;
            bus_ack       <= 1'b0;
            bus_err       <= 1'b0;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            wait_cnt <= wait_nx;
            to_cnt   <= to_nx;
            cs       <= cs_nx;
            bus_ack  <= (state_nx == S_ACK);
            bus_err  <= (state_nx == S_ERR);
            if ((state_nx == S_ERR) && (state != S_ERR)) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                last_err_addr <= addr_byte;
            end
        end
    end

    // Read data mux from the latched region, zero when no region is selected
    always_comb begin
        data_in = '0;
        if (|cs) begin
            data_in = region_dout[idx*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// Directed self-checking bench for attex_bus_ctrl.
// Map: r0 ROM 0x0xxxxx w0, r1 MCD212 0x2xxxxx w3, r2 slave 0x3xxxxx w2 ext,
// r3 CDIC 0x20xxxx w1 (overlaps r1), r4 NVRAM 0x40xxxx w1. TIMEOUT=20.
// Sample index k means "just after the k-th edge following the request edge T",
// i.e. the cycle the specification calls T+1+k.
module tb_attex_bus_ctrl;

    localparam int NR = 5;
    localparam int DW = 16;

    logic            clk;
    logic            resetn;
    logic            as;
    logic            uds;
    logic            lds;
    logic            write_strobe;
    logic [23:1]     addr;
    logic [NR*DW-1:0] region_dout;
    logic [NR-1:0]   region_ack;
    logic [NR-1:0]   cs;
    logic [DW-1:0]   data_in;
    logic            bus_ack;
    logic            bus_err;
    logic [7:0]      err_count;
    logic [23:0]     last_err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    attex_bus_ctrl #(
        .NUM_REGIONS   (NR),
        .DATA_W        (DW),
        .REGION_BASE   ({24'h400000, 24'h200000, 24'h300000, 24'h200000, 24'h000000}),
        .REGION_MASK   ({24'hFF0000, 24'hFF0000, 24'hF00000, 24'hF00000, 24'hF00000}),
        .REGION_WAIT   ({4'd1, 4'd1, 4'd2, 4'd3, 4'd0}),
        .REGION_EXTACK (5'b00100),
        .TIMEOUT       (20)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .as            (as),
        .uds           (uds),
        .lds           (lds),
        .write_strobe  (write_strobe),
        .addr          (addr),
        .region_dout   (region_dout),
        .region_ack    (region_ack),
        .cs            (cs),
        .data_in       (data_in),
        .bus_ack       (bus_ack),
        .bus_err       (bus_err),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] a, input logic wr);
        addr         = a[23:1];
        write_strobe = wr;
        as           = 1'b1;
        uds          = 1'b1;
        lds          = ~wr;
    endtask

    task automatic end_txn();
        as  = 1'b0;
        uds = 1'b0;
        lds = 1'b0;
        tick();
    endtask

    // Runs n cycles; region_ack[2] is presented so it is sampled at the edge
    // that produces index pulse_k (negative: never).
    task automatic observe(input int n, input int pulse_k,
                           output int first_ack, output int n_ack,
                           output int first_err, output logic [15:0] ack_data,
                           output logic [4:0] cs0);
        first_ack = -1;
        n_ack     = 0;
        first_err = -1;
        ack_data  = '0;
        cs0       = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) cs0 = cs;
            if (bus_ack) begin
                if (first_ack < 0) begin
                    first_ack = k;
                    ack_data  = data_in;
                end
                n_ack++;
            end
            if (bus_err && first_err < 0) first_err = k;
            region_ack = (k + 1 == pulse_k) ? 5'b00100 : 5'b00000;
        end
        region_ack = '0;
    endtask

    int          fa, na, fe;
    logic [15:0] ad;
    logic [4:0]  c0;

    initial begin
        resetn       = 1'b0;
        as           = 1'b0;
        uds          = 1'b0;
        lds          = 1'b0;
        write_strobe = 1'b0;
        addr         = '0;
        region_ack   = '0;
        region_dout  = {16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000};
        tick();
        tick();
        check("rst_cs",      32'(cs), 32'h0);
        check("rst_ack",     32'(bus_ack), 32'h0);
        check("rst_err",     32'(bus_err), 32'h0);
        check("rst_errcnt",  32'(err_count), 32'h0);
        check("rst_lastadr", 32'(last_err_addr), 32'h0);
        check("rst_data",    32'(data_in), 32'h0);
        resetn = 1'b1;
        tick();

        // ROM, zero wait: ack and data at index 0
        start(24'h000100, 1'b0);
        observe(3, -1, fa, na, fe, ad, c0);
        check("rom_cs0",    32'(c0), 32'h01);
        check("rom_ack_at", 32'(fa), 32'd0);
        check("rom_ack_n",  32'(na), 32'd1);
        check("rom_data",   32'(ad), 32'hD000);
        check("rom_noerr",  32'(fe), 32'hFFFF_FFFF);
        check("rom_hold_cs", 32'(cs), 32'h01);
        end_txn();
        check("rom_cs_off", 32'(cs), 32'h0);

        // MCD212, three wait states, write access
        start(24'h280000, 1'b1);
        observe(8, -1, fa, na, fe, ad, c0);
        check("mcd_cs0",    32'(c0), 32'h02);
        check("mcd_ack_at", 32'(fa), 32'd3);
        check("mcd_ack_n",  32'(na), 32'd1);
        check("mcd_data",   32'(ad), 32'hD001);
        check("mcd_hold_cs", 32'(cs), 32'h02);
        end_txn();
        check("mcd_cs_off", 32'(cs), 32'h0);
        check("mcd_data_off", 32'(data_in), 32'h0);

        // NVRAM, one wait state
        start(24'h400010, 1'b0);
        observe(4, -1, fa, na, fe, ad, c0);
        check("nv_cs0",    32'(c0), 32'h10);
        check("nv_ack_at", 32'(fa), 32'd1);
        check("nv_data",   32'(ad), 32'hD004);
        end_txn();

        // Slave, external ack sampled at edge T+10
        start(24'h300020, 1'b0);
        observe(15, 10, fa, na, fe, ad, c0);
        check("slv_cs0",    32'(c0), 32'h04);
        check("slv_ack_at", 32'(fa), 32'd10);
        check("slv_ack_n",  32'(na), 32'd1);
        check("slv_data",   32'(ad), 32'hD002);
        check("slv_noerr",  32'(fe), 32'hFFFF_FFFF);
        end_txn();

        // Slave, early ack ignored, then timeout at edge T+20
        start(24'h300040, 1'b0);
        observe(25, 1, fa, na, fe, ad, c0);
        check("to_ack_n",   32'(na), 32'd0);
        check("to_err_at",  32'(fe), 32'd20);
        check("to_errcnt",  32'(err_count), 32'd1);
        check("to_lastadr", 32'(last_err_addr), 32'h300040);
        check("to_cs_err",  32'(cs), 32'h0);
        end_txn();
        check("to_err_off", 32'(bus_err), 32'h0);

        // Unmapped access
        start(24'h700000, 1'b0);
        tick();
        check("um_err",     32'(bus_err), 32'h1);
        check("um_cs",      32'(cs), 32'h0);
        check("um_errcnt",  32'(err_count), 32'd2);
        check("um_lastadr", 32'(last_err_addr), 32'h700000);
        tick();
        check("um_err_hold", 32'(bus_err), 32'h1);
        check("um_errcnt_hold", 32'(err_count), 32'd2);
        end_txn();
        check("um_err_off", 32'(bus_err), 32'h0);

        for (int i = 0; i < 300; i++) begin
            start(24'h700000, 1'b0);
            tick();
            end_txn();
        end
        check("um_errcnt_sat", 32'(err_count), 32'd255);

        // Overlap r1/r3, then abort in WAIT
        start(24'h201000, 1'b0);
        tick();
        check("ov_cs",   32'(cs), 32'h02);
        check("ov_data", 32'(data_in), 32'hD001);
        as  = 1'b0;
        uds = 1'b0;
        lds = 1'b0;
        observe(6, -1, fa, na, fe, ad, c0);
        check("ab_cs_next", 32'(c0), 32'h0);
        check("ab_no_ack",  32'(na), 32'd0);
        check("ab_no_err",  32'(fe), 32'hFFFF_FFFF);

        // Reset in the middle of WAIT
        start(24'h280000, 1'b0);
        tick();
        check("rw_cs", 32'(cs), 32'h02);
        resetn = 1'b0;
        tick();
        check("rw_cs_off",   32'(cs), 32'h0);
        check("rw_ack",      32'(bus_ack), 32'h0);
        check("rw_err",      32'(bus_err), 32'h0);
        check("rw_errcnt",   32'(err_count), 32'h0);
        check("rw_lastadr",  32'(last_err_addr), 32'h0);
        check("rw_data",     32'(data_in), 32'h0);
        resetn = 1'b1;
        end_txn();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/attex_bus_ctrl.md
# attex_bus_ctrl

Parametrised system-bus glue for the SCC68070 CPU. It replaces hand-written chip-select, bus-ack and bus-error logic with a single block. It decodes `NUM_REGIONS` address windows, drives registered one-hot chip selects and inserts per-region wait states. Regions can instead wait for an external slave acknowledge. Unmapped accesses and timed-out accesses are answered with a bus error, and error statistics are kept for debug. It sits between the CPU bus pins and the peripheral blocks (ROM, MCD212, CDIC, slave, NVRAM).

## Interface
Parameters:
- `NUM_REGIONS`, 5, number of decoded windows (1..16).
- `DATA_W`, 16, CPU data width.
- `REGION_BASE`, all 0, packed `NUM_REGIONS`×24 byte base addresses.
- `REGION_MASK`, all 0, packed `NUM_REGIONS`×24 compare masks. A region hits when `(addr_byte & MASK) == (BASE & MASK)`. An all-zero mask means the region is disabled.
- `REGION_WAIT`, all 0, packed `NUM_REGIONS`×4 wait states (0..15).
- `REGION_EXTACK`, all 0, `NUM_REGIONS` bits; a 1 means the region completes on `region_ack[i]`.
- `TIMEOUT`, 255, maximum cycles from decode to acknowledge (1..65535).

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset.
- `as` in 1: CPU address strobe (active high).
- `uds`, `lds` in 1 each: upper/lower data strobes.
- `write_strobe` in 1: 1 = write.
- `addr` in 23: CPU word address `[23:1]`.
- `region_dout` in `NUM_REGIONS`×`DATA_W`: packed read data from the peripherals.
- `region_ack` in `NUM_REGIONS`: external acknowledges.
- `cs` out `NUM_REGIONS`: registered one-hot chip selects.
- `data_in` out `DATA_W`: read data to the CPU.
- `bus_ack` out 1: transfer acknowledge pulse.
- `bus_err` out 1: bus error.
- `err_count` out 8: saturating count of bus errors.
- `last_err_addr` out 24: byte address of the most recent error.

## Operation
- Request condition: `req = as && (uds || lds)`.
- Decode: the lowest-index hitting region wins. No hit means an unmapped access.
- State machine:
  - IDLE: when `req` is sampled, latch the region index and load `wait_cnt = REGION_WAIT[i]` and `to_cnt = 0`, then go to WAIT. With no hit, go to ERR.
  - WAIT: while `wait_cnt != 0`, decrement it. At 0:
    - an internal-ack region goes to ACK;
    - an external-ack region stays in WAIT until `region_ack[i]` is sampled high, then goes to ACK.
    - `to_cnt` increments every WAIT cycle; when `to_cnt == TIMEOUT` the block goes to ERR.
  - ACK: `bus_ack` is high for exactly this one cycle, then the block goes to HOLD.
  - HOLD: wait for `!as`, then return to IDLE.
  - ERR: `bus_err` stays high until `!as` is sampled, then the block returns to IDLE. On entry to ERR, increment `err_count` (saturating at 255) and load `last_err_addr`.
- Abort: `!as` in WAIT returns to IDLE. There is no ack and no error, and `cs` clears the next cycle.
- `cs[i]` is high in WAIT, ACK and HOLD for the latched region, and 0 otherwise.
- `data_in` = `region_dout[latched i]` while any `cs` bit is high, otherwise 0. The mux is combinational from the latched index, so read data is valid in the ACK cycle.
- Writes and reads behave identically; `write_strobe` is not used for decode.
- Reset (`resetn` low at an edge) forces IDLE with `cs=0`, `bus_ack=0`, `bus_err=0`, `err_count=0`, `last_err_addr=0`. This holds even mid-transaction; the CPU cycle is then never acknowledged.

## Timing
- `req` is first sampled at edge T; `cs` is high from T+1.
- Internal ack: `bus_ack` is high in cycle T+1+WAIT, so WAIT=0 gives an ack one cycle after the request.
- External ack: `region_ack` is sampled high at edge E with `wait_cnt == 0`, and `bus_ack` is high in cycle E+1. An ack asserted before the wait states expire is ignored.
- If `region_ack` and the timeout occur at the same edge, the ack wins.
- Unmapped request sampled at T: `bus_err` is high from T+1 until the cycle after `!as` is sampled.
- Back-to-back transactions require `as` low for at least one sampled edge; `bus_ack` never fires twice for one `as` assertion.
- All outputs are registered except `data_in`.

## Test plan
- ROM region, WAIT=0, read with `addr_byte=0x000100`: `cs[0]` high from T+1, `bus_ack` a single pulse at T+1, `data_in` = `region_dout[0]` in that cycle.
- MCD212 region, WAIT=3: `bus_ack` at T+4 only; `cs` stays high through HOLD until `as` drops, then reads 0 the next cycle.
- Slave region with EXTACK: `region_ack` pulses 10 cycles after T gives `bus_ack` at T+11. With no ack and `TIMEOUT=20`, `bus_err` is asserted at T+21, `err_count=1`, and `last_err_addr` holds the access address.
- Access to `0x700000` (unmapped): `bus_err` at T+1 and no `cs`. After 300 repeated unmapped accesses, `err_count=255`.
- Overlapping regions 1 and 3 both hit: only `cs[1]` asserts.
- `as` dropped in WAIT → no `bus_ack`/`bus_err` and `cs=0` next cycle. `resetn` low mid-WAIT → all outputs 0 at the following cycle.
